// File: rtl/dcache_refill_ctrl.sv
// Data-cache line refill controller: issues one line read per miss, assembles the
// returned word burst, forwards the missing word early and writes the full line.
module dcache_refill_ctrl #(
  parameter int Offset_len = 6
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             miss_req,
  input  logic [31:0]                      miss_addr,
  output logic                             miss_ready,
  output logic                             rd_req,
  output logic [31:0]                      rd_addr,
  input  logic                             rd_ack,
  input  logic                             ret_valid,
  input  logic [31:0]                      ret_data,
  output logic                             crit_valid,
  output logic [31:0]                      crit_data,
  output logic                             refill_we,
  output logic [31:0]                      refill_addr,
  output logic [2**(Offset_len+3)-1:0]     refill_block,
  output logic                             refill_done,
  output logic [1:0]                       fsm_state
);

  // Handshakes: a miss transfers when miss_req && miss_ready; a line read transfers
  // when rd_req && rd_ack; each ret_valid cycle in RECV delivers the next word.
  localparam int CntW  = Offset_len - 2;
  localparam int LineW = 2**(Offset_len+3);

  typedef enum logic [1:0] {IDLE, REQ, RECV, WRITE} state_t;

  state_t            state, state_nxt;
  logic [31:0]       addr_q;
  logic [CntW-1:0]   cnt;
  logic [LineW-1:0]  buffer;
  logic [31:0]       line_addr;
  logic [CntW-1:0]   crit_word;

  assign line_addr = {addr_q[31:Offset_len], {Offset_len{1'b0}}};
  assign crit_word = addr_q[Offset_len-1:2];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (miss_req) state_nxt = REQ;
      REQ:   if (rd_ack) state_nxt = RECV;
      RECV:  if (ret_valid && cnt == CntW'(2**CntW - 1)) state_nxt = WRITE;
      WRITE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    miss_ready  = (state == IDLE);
    rd_req      = (state == REQ);
    refill_we   = (state == WRITE);
    refill_done = (state == WRITE);
  end

  // cnt wraps to zero on the last beat, so the next miss also starts from word 0.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_q     <= '0;
      cnt        <= '0;
      buffer     <= '0;
      crit_valid <= 1'b0;
      crit_data  <= '0;
    end else begin
      crit_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (miss_req) begin
            addr_q <= miss_addr;
            cnt    <= '0;
          end
        end
        RECV: begin
          if (ret_valid) begin
            buffer[{cnt, 5'd0} +: 32] <= ret_data;
            cnt <= cnt + CntW'(1);
            if (cnt == crit_word) begin
              crit_valid <= 1'b1;
              crit_data  <= ret_data;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Address and line only change when a new miss is accepted or a burst refills.
  assign rd_addr      = line_addr;
  assign refill_addr  = line_addr;
  assign refill_block = buffer;
  assign fsm_state    = state;

endmodule

// File: tb/tb_dcache_refill_ctrl.sv
// Directed and randomized bench for dcache_refill_ctrl; expectations come from a
// line-level model (aligned address, packed word array, cycle arithmetic).
module tb_dcache_refill_ctrl;

  localparam int OFF = 6;
  localparam int N   = 16;
  localparam int LW  = 512;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          miss_req = 1'b0;
  logic [31:0]   miss_addr = '0;
  logic          miss_ready;
  logic          rd_req;
  logic [31:0]   rd_addr;
  logic          rd_ack = 1'b0;
  logic          ret_valid = 1'b0;
  logic [31:0]   ret_data = '0;
  logic          crit_valid;
  logic [31:0]   crit_data;
  logic          refill_we;
  logic [31:0]   refill_addr;
  logic [LW-1:0] refill_block;
  logic          refill_done;
  logic [1:0]    fsm_state;

  dcache_refill_ctrl #(.Offset_len(OFF)) dut (
    .clk(clk), .rstn(rstn),
    .miss_req(miss_req), .miss_addr(miss_addr), .miss_ready(miss_ready),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
    .ret_valid(ret_valid), .ret_data(ret_data),
    .crit_valid(crit_valid), .crit_data(crit_data),
    .refill_we(refill_we), .refill_addr(refill_addr), .refill_block(refill_block),
    .refill_done(refill_done), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  int            tests = 0;
  int            fails = 0;
  int            cyc = 0;
  logic [LW-1:0] last_block;
  logic [31:0]   last_crit;
  logic [31:0]   last_rd_addr;
  int            last_lat;
  logic          last_crit_at_write;

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_line(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [LW-1:0] pack_line(input logic [31:0] d [N]);
    logic [LW-1:0] line;
    line = '0;
    for (int k = 0; k < N; k++) line[k*32 +: 32] = d[k];
    return line;
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk_bit({tag, "_miss_ready"}, miss_ready, 1'b1);
    chk_bit({tag, "_rd_req"}, rd_req, 1'b0);
    chk_bit({tag, "_crit_valid"}, crit_valid, 1'b0);
    chk_bit({tag, "_refill_we"}, refill_we, 1'b0);
    chk_bit({tag, "_refill_done"}, refill_done, 1'b0);
    chk_word({tag, "_crit_data"}, crit_data, 32'h0);
    chk_word({tag, "_rd_addr"}, rd_addr, 32'h0);
    chk_word({tag, "_refill_addr"}, refill_addr, 32'h0);
    chk_line({tag, "_refill_block"}, refill_block, '0);
  endtask

  // Starts in an IDLE cycle, ends in the IDLE cycle right after WRITE.
  task automatic do_refill(input logic [31:0] addr, input int ack_dly, input int gap_min,
                           input int gap_max, input bit hold_next, input logic [31:0] next_addr,
                           input logic [31:0] d [N]);
    logic [31:0] line_a;
    int          w, t0, rd_cnt, gaps, g;
    bit          hit;
    line_a = addr & ~((32'd1 << OFF) - 32'd1);
    w      = int'(addr[OFF-1:2]);
    rd_cnt = 0;
    gaps   = 0;
    hit    = 1'b0;
    last_crit_at_write = 1'b0;

    chk_bit("accept_ready", miss_ready, 1'b1);
    miss_req  = 1'b1;
    miss_addr = addr;
    t0 = cyc;
    tick();
    if (hold_next) miss_addr = next_addr;
    else miss_req = 1'b0;

    last_rd_addr = rd_addr;
    for (int i = 0; i <= ack_dly; i++) begin
      chk_word("rd_addr", rd_addr, line_a);
      chk_bit("req_busy", miss_ready, 1'b0);
      if (rd_req) rd_cnt++;
      rd_ack    = (i == ack_dly);
      ret_valid = 1'($urandom_range(0, 1));
      ret_data  = $urandom;
      tick();
    end
    rd_ack = 1'b0;
    chk_word("rd_req_cycles", 32'(rd_cnt), 32'(ack_dly + 1));

    for (int k = 0; k < N; k++) begin
      g = $urandom_range(gap_max, gap_min);
      for (int j = 0; j <= g; j++) begin
        chk_bit("crit_valid", crit_valid, hit);
        if (hit) begin
          chk_word("crit_data", crit_data, d[w]);
          last_crit = crit_data;
        end
        chk_bit("recv_we", refill_we, 1'b0);
        chk_bit("recv_rd_req", rd_req, 1'b0);
        chk_bit("recv_busy", miss_ready, 1'b0);
        rd_ack    = 1'($urandom_range(0, 1));
        ret_valid = (j == g);
        ret_data  = (j == g) ? d[k] : $urandom;
        hit       = (j == g) && (k == w);
        tick();
      end
      gaps += g;
    end

    rd_ack    = 1'b1;
    ret_valid = 1'b1;
    ret_data  = $urandom;
    chk_bit("write_crit_valid", crit_valid, hit);
    if (hit) begin
      chk_word("write_crit_data", crit_data, d[w]);
      last_crit = crit_data;
      last_crit_at_write = crit_valid;
    end
    chk_bit("write_we", refill_we, 1'b1);
    chk_bit("write_done", refill_done, 1'b1);
    chk_bit("write_busy", miss_ready, 1'b0);
    chk_word("refill_addr", refill_addr, line_a);
    chk_line("refill_block", refill_block, pack_line(d));
    last_lat   = cyc - t0;
    last_block = refill_block;
    chk_word("write_latency", 32'(last_lat), 32'(2 + ack_dly + N + gaps));
    tick();

    rd_ack    = 1'b0;
    ret_valid = 1'b0;
    chk_bit("idle_we", refill_we, 1'b0);
    chk_bit("idle_done", refill_done, 1'b0);
    chk_bit("idle_crit_valid", crit_valid, 1'b0);
    chk_word("idle_crit_hold", crit_data, d[w]);
    chk_bit("idle_ready", miss_ready, 1'b1);
    chk_word("idle_refill_addr", refill_addr, line_a);
    chk_line("idle_block_hold", refill_block, pack_line(d));
  endtask

  initial begin
    logic [31:0] d [N];
    logic [31:0] d2 [N];
    logic [31:0] a1, a2;
    logic [31:0] addrs [8];

    repeat (2) tick();
    chk_reset_outputs("rst");
    rstn = 1'b1;
    tick();
    chk_reset_outputs("post_rst");

    // Worked example: word 13 of the line at 0x1200, zero-gap burst.
    for (int k = 0; k < N; k++) d[k] = 32'hA0 + 32'(k);
    do_refill(32'h0000_1234, 0, 0, 0, 1'b0, 32'h0, d);
    chk_word("ex_rd_addr", last_rd_addr, 32'h0000_1200);
    chk_word("ex_crit", last_crit, 32'h0000_00AD);
    chk_word("ex_w13", last_block[447:416], 32'h0000_00AD);
    chk_word("ex_w0", last_block[31:0], 32'h0000_00A0);
    chk_word("ex_latency", 32'(last_lat), 32'd18);
    tick();

    // Slow acknowledge and every-other-cycle beats.
    for (int k = 0; k < N; k++) d[k] = $urandom;
    do_refill($urandom, 5, 1, 1, 1'b0, 32'h0, d);
    repeat (2) tick();

    // Second miss held throughout the first refill, taken right after WRITE.
    a1 = $urandom;
    a2 = a1 ^ 32'h0001_0040;
    for (int k = 0; k < N; k++) begin
      d[k]  = $urandom;
      d2[k] = $urandom;
    end
    do_refill(a1, 1, 0, 2, 1'b1, a2, d);
    do_refill(a2, 0, 0, 1, 1'b0, 32'h0, d2);
    chk_word("b2b_rd_addr", last_rd_addr, a2 & 32'hFFFF_FFC0);
    tick();

    // Critical word first and last in the line.
    for (int k = 0; k < N; k++) d[k] = $urandom;
    do_refill(32'hFFFF_FFC0, 0, 0, 0, 1'b0, 32'h0, d);
    chk_word("w0_crit", last_crit, d[0]);
    do_refill(32'h1000_003C, 0, 0, 0, 1'b0, 32'h0, d);
    chk_bit("w15_crit_at_write", last_crit_at_write, 1'b1);
    tick();

    // Reset in the middle of a burst.
    miss_req  = 1'b1;
    miss_addr = $urandom;
    tick();
    miss_req = 1'b0;
    rd_ack   = 1'b1;
    tick();
    rd_ack = 1'b0;
    for (int k = 0; k < 7; k++) begin
      ret_valid = 1'b1;
      ret_data  = $urandom;
      tick();
    end
    ret_valid = 1'b0;
    rstn = 1'b0;
    #1;
    chk_reset_outputs("mid_rst");
    tick();
    rstn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      ret_valid = 1'b1;
      ret_data  = $urandom;
      rd_ack    = 1'($urandom_range(0, 1));
      tick();
      chk_bit("stray_we", refill_we, 1'b0);
      chk_bit("stray_crit", crit_valid, 1'b0);
      chk_bit("stray_ready", miss_ready, 1'b1);
      chk_line("stray_block", refill_block, '0);
    end
    ret_valid = 1'b0;
    rd_ack    = 1'b0;
    for (int k = 0; k < N; k++) d[k] = $urandom;
    do_refill($urandom, 2, 0, 1, 1'b0, 32'h0, d);

    // Randomized refills, some chained back to back.
    for (int i = 0; i < 8; i++) addrs[i] = $urandom;
    for (int i = 0; i < 7; i++) begin
      bit chain;
      chain = 1'($urandom_range(0, 1));
      for (int k = 0; k < N; k++) d[k] = $urandom;
      do_refill(addrs[i], $urandom_range(0, 4), 0, $urandom_range(0, 2), chain, addrs[i+1], d);
      if (!chain) repeat ($urandom_range(0, 2)) tick();
    end
    miss_req = 1'b0;
    repeat (2) tick();

    $display("[TB] final fsm_state=%0d cycles=%0d", fsm_state, cyc);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dcache_refill_ctrl.md
DCACHE_REFILL_CTRL -- requirements
Module: dcache_refill_ctrl

Interface
REQ-001 Parameter: Offset_len, default 6, line-offset bits; line = 2^(Offset_len+3) bits (512), words per line N = 2^(Offset_len-2) (16).
REQ-002 clk  in  1  system clock, all state on rising edge.
REQ-003 rstn  in  1  reset, asynchronous, active-low.
REQ-004 miss_req  in  1  pipeline requests line refill.
REQ-005 miss_addr  in  32  byte address of missing access.
REQ-006 miss_ready  out  1  controller can accept a miss.
REQ-007 rd_req  out  1  line read request to memory side.
REQ-008 rd_addr  out  32  line-aligned read address.
REQ-009 rd_ack  in  1  memory side accepts rd_req.
REQ-010 ret_valid  in  1  one returned word valid this cycle.
REQ-011 ret_data  in  32  returned word, in ascending word order 0..N-1.
REQ-012 crit_valid  out  1  one-cycle pulse: requested word available.
REQ-013 crit_data  out  32  requested word (early restart).
REQ-014 refill_we  out  1  one-cycle write strobe to data array.
REQ-015 refill_addr  out  32  line-aligned address of written line.
REQ-016 refill_block  out  2^(Offset_len+3)  assembled line; word k at bits [32k+31:32k].
REQ-017 refill_done  out  1  one-cycle pulse, refill complete.

Function
REQ-018 FSM states IDLE, REQ, RECV, WRITE; miss_ready = (state==IDLE), combinational.
REQ-019 IDLE: miss_req=1 -> latch miss_addr into addr_q, clear word counter cnt, go REQ next cycle; miss_req=0 -> stay.
REQ-020 REQ: rd_req=1, rd_addr = addr_q with low Offset_len bits forced 0; rd_req held until rd_ack; rd_ack=1 -> RECV.
REQ-021 rd_ack outside REQ ignored; rd_req=0 in every other state.
REQ-022 RECV: each cycle ret_valid=1 -> store ret_data in buffer word cnt, cnt increments; ret_valid=0 -> no change, no timeout.
REQ-023 RECV: ret_valid=1 with cnt==N-1 -> stores last word, go WRITE; cnt wraps to 0.
REQ-024 ret_valid in IDLE, REQ or WRITE ignored; buffer unchanged.
REQ-025 crit_valid pulses 1 cycle after the ret_valid cycle where cnt == addr_q[Offset_len-1:2]; crit_data = that word, registered, held until next crit pulse.
REQ-026 WRITE: refill_we=1 and refill_done=1 for exactly one cycle; refill_addr = line-aligned addr_q; refill_block = full buffer; go IDLE next cycle.
REQ-027 refill_block and refill_addr stable from WRITE until next accepted miss; refill_we/refill_done 0 otherwise.
REQ-028 Latency: miss accept (IDLE) -> rd_req high next cycle; last ret_valid -> refill_we next cycle; zero-gap burst, rd_ack same cycle as rd_req: accept at T, refill_we at T+N+2.
REQ-029 miss_req during REQ/RECV/WRITE not accepted (miss_ready=0); requester holds request.
REQ-030 Miss accepted the cycle after WRITE (back-to-back) allowed; no idle bubble beyond IDLE cycle.

Reset
REQ-031 rstn=0 -> state IDLE, cnt 0, addr_q 0, buffer 0; rd_req, crit_valid, refill_we, refill_done 0; crit_data, rd_addr, refill_addr, refill_block 0; miss_ready 1.
REQ-032 Reset mid-REQ/RECV/WRITE abandons refill: no refill_we issued, partial buffer discarded; later ret_valid beats ignored until new miss reaches RECV.

Verification
REQ-033 miss_addr=0x0000_1234, rd_ack immediate, 16 back-to-back words 0xA0..0xAF -> rd_addr=0x0000_1200; crit_valid with crit_data=0xAD (word 13); refill_we at T+18, refill_block[447:416]=0xAD, [31:0]=0xA0.
REQ-034 rd_ack delayed 5 cycles, ret_valid gaps every other cycle -> rd_req held 6 cycles, exactly one refill_we, block matches sequence.
REQ-035 miss_req held during RECV with different address -> not accepted until after refill_done; second refill uses new address.
REQ-036 rstn low after 7 returned words, then release -> no refill_we, all outputs reset values, stray ret_valid ignored, next miss refills correctly.
REQ-037 miss_addr=0xFFFF_FFC0 (word 0) -> crit_valid one cycle after first beat; miss_addr=0x...3C (word 15) -> crit_valid same cycle as refill_we.
